// File: rtl/ex_result_stage.sv
// ex_result_stage
// Execute-stage result register and branch resolver. Captures the ALU result
// and flags, resolves the branch condition, and hands registered results to
// the memory stage through a main/skid pair so a stall never loses an op.
// A taken branch or jump raises a single-cycle PC redirect. Any op accepted
// during that redirect cycle is on the wrong path and is swallowed.

module ex_result_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] result_alu,
    input  logic            zero_flag,
    input  logic            carry_flag,
    input  logic            negative_flag,
    input  logic            overflow_flag,
    input  logic [2:0]      br_op,
    input  logic [XLEN-1:0] br_target,
    input  logic [4:0]      rd,
    input  logic            reg_we,
    input  logic            flush,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_reg_we,
    output logic [3:0]      out_flags,

    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_JUMP = 3'b011,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } brOp_e;

    // One held op; flags are kept as {N,Z,C,V}.
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            we;
        logic [3:0]      flags;
    } entry_t;

    entry_t          main_q, main_d;
    entry_t          skid_q, skid_d;
    logic            mainValid_q, mainValid_d;
    logic            skidValid_q, skidValid_d;
    logic            redirValid_q, redirValid_d;
    logic [XLEN-1:0] redirPc_q, redirPc_d;

    entry_t          incoming;
    logic            brTaken;
    logic            accept;
    logic            store;

    // Skid occupancy alone throttles upstream; reset holds it off as well.
    assign in_ready = ~skidValid_q & ~rst;
    assign accept   = in_valid & in_ready;
    // Ops accepted while a redirect is being issued belong to the wrong path.
    assign store    = accept & ~redirValid_q;

    // Pack the incoming op into entry form.
    always_comb begin
        incoming        = '0;
        incoming.result = result_alu;
        incoming.rd     = rd;
        incoming.we     = reg_we;
        incoming.flags  = {negative_flag, zero_flag, carry_flag, overflow_flag};
    end

    // Branch condition from the flags of rs1 - rs2; carry is the unsigned borrow.
    always_comb begin
        brTaken = 1'b0;
        case (br_op)
            BR_BEQ:  brTaken = zero_flag;
            BR_BNE:  brTaken = ~zero_flag;
            BR_JUMP: brTaken = 1'b1;
            BR_BLT:  brTaken = negative_flag ^ overflow_flag;
            BR_BGE:  brTaken = ~(negative_flag ^ overflow_flag);
            BR_BLTU: brTaken = carry_flag;
            BR_BGEU: brTaken = ~carry_flag;
            default: brTaken = 1'b0;
        endcase
    end

    // Next-state for the main/skid pair and the redirect pulse; flush wins over everything.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        mainValid_d  = mainValid_q;
        skidValid_d  = skidValid_q;
        redirValid_d = 1'b0;
        redirPc_d    = redirPc_q;

        if (flush) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else begin
            if (!mainValid_q || out_ready) begin
                // Main is free this cycle; the skid entry is older, so it goes first.
                if (skidValid_q) begin
                    main_d      = skid_q;
                    mainValid_d = 1'b1;
                    skidValid_d = 1'b0;
                end else if (store) begin
                    main_d      = incoming;
                    mainValid_d = 1'b1;
                end else begin
                    mainValid_d = 1'b0;
                end
            end else if (store) begin
                skid_d      = incoming;
                skidValid_d = 1'b1;
            end

            if (store && brTaken) begin
                redirValid_d = 1'b1;
                redirPc_d    = br_target;
            end
        end
    end

    // State registers with synchronous reset; dropping everything held and any pending redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            mainValid_q  <= 1'b0;
            skidValid_q  <= 1'b0;
            redirValid_q <= 1'b0;
            redirPc_q    <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            mainValid_q  <= mainValid_d;
            skidValid_q  <= skidValid_d;
            redirValid_q <= redirValid_d;
            redirPc_q    <= redirPc_d;
        end
    end

    assign out_valid      = mainValid_q;
    assign out_result     = main_q.result;
    assign out_rd         = main_q.rd;
    assign out_reg_we     = main_q.we;
    assign out_flags      = main_q.flags;
    assign redirect_valid = redirValid_q;
    assign redirect_pc    = redirPc_q;

endmodule
